// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: frame receiver, prefix tracking, press strobes.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
//
// Ports:
//   clk          system clock, rising edge
//   iReset       synchronous active-high reset
//   iPS2_CLK     raw PS/2 clock (asynchronous)
//   iPS2_DAT     raw PS/2 data (asynchronous)
//   spacePressed one-cycle pulse on a fresh SPACE_CODE make
//   onePressed   one-cycle pulse on a fresh ONE_CODE make
//   oScanCode    last valid byte, held between frames
//   oScanValid   one-cycle pulse when oScanCode updates
//   oFrameError  one-cycle pulse on a discarded frame
`timescale 1ns/1ps
module ps2_key_decoder #(
    parameter int         TIMEOUT_CYCLES = 10000,
    parameter logic [7:0] SPACE_CODE     = 8'h29,
    parameter logic [7:0] ONE_CODE       = 8'h16
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic       spacePressed,
    output logic       onePressed,
    output logic [7:0] oScanCode,
    output logic       oScanValid,
    output logic       oFrameError
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam logic [7:0] BRK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_e;

    state_e state_q, state_d;

    // ck_q[1] is the synchronised clock, ck_q[2] its previous value
    logic [2:0] ck_q;
    logic [1:0] dt_q;
    logic       fall_q;
    logic       bit_q;

    logic [3:0]      cnt_q;
    logic [7:0]      sh_q;
    logic            stop_q;
    logic [WD_W-1:0] wd_q;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_q;
`endif

    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       sheld_q, sheld_d;
    logic       oheld_q, oheld_d;

    logic       space_q, space_d;
    logic       one_q, one_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [7:0] code_q, code_d;

    logic start_edge;
    logic stray_edge;
    logic last_edge;
    logic timeout;
    logic frame_ok;

    // Synchroniser idles high so reset never fabricates a falling edge.
    // The edge pulse and its data bit are registered together.
    always_ff @(posedge clk) begin
        if (iReset) begin
            ck_q   <= 3'b111;
            dt_q   <= 2'b11;
            fall_q <= 1'b0;
            bit_q  <= 1'b1;
        end else begin
            ck_q   <= {ck_q[1:0], iPS2_CLK};
            dt_q   <= {dt_q[0], iPS2_DAT};
            fall_q <= ck_q[2] & ~ck_q[1];
            bit_q  <= dt_q[1];
        end
    end

    assign start_edge = (state_q == S_IDLE) && fall_q && !bit_q;
    assign stray_edge = (state_q == S_IDLE) && fall_q && bit_q;
    assign last_edge  = (state_q == S_SHIFT) && fall_q
                        && (cnt_q == 4'd10);
    assign timeout    = (state_q == S_SHIFT) && (wd_q == WD_MAX);

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = stop_q & (^{sh_q, par_q});
`else
    assign frame_ok = stop_q;
`endif

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (last_edge) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        space_d = 1'b0;
        one_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        sheld_d = sheld_q;
        oheld_d = oheld_q;

        if (stray_edge || timeout) begin
            err_d = 1'b1;
        end
        if (timeout) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end

        if (state_q == S_CHECK) begin
            if (!frame_ok) begin
                err_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                code_d  = sh_q;
                if (sh_q == EXT_CODE) begin
                    ext_d = 1'b1;
                end else if (sh_q == BRK_CODE) begin
                    brk_d = 1'b1;
                end else if (ext_q) begin
                    // Extended keys never alias the plain keys
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (brk_q) begin
                    brk_d = 1'b0;
                    if (sh_q == SPACE_CODE) begin
                        sheld_d = 1'b0;
                    end
                    if (sh_q == ONE_CODE) begin
                        oheld_d = 1'b0;
                    end
                end else begin
                    // Typematic repeats arrive as makes while held
                    if (sh_q == SPACE_CODE && !sheld_q) begin
                        space_d = 1'b1;
                        sheld_d = 1'b1;
                    end
                    if (sh_q == ONE_CODE && !oheld_q) begin
                        one_d   = 1'b1;
                        oheld_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            cnt_q  <= 4'd0;
            sh_q   <= 8'h00;
            stop_q <= 1'b0;
            wd_q   <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_q  <= 1'b0;
`endif
        end else begin
            if (fall_q || timeout) begin
                wd_q <= '0;
            end else if (state_q == S_SHIFT) begin
                wd_q <= wd_q + 1'b1;
            end

            if (start_edge) begin
                cnt_q <= 4'd1;
            end else if (timeout || state_q == S_CHECK) begin
                cnt_q <= 4'd0;
            end else if (state_q == S_SHIFT && fall_q) begin
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q <= 4'd8) begin
                    sh_q <= {bit_q, sh_q[7:1]};
                end
`ifdef PS2_PARITY_CHECK_EN
                if (cnt_q == 4'd9) begin
                    par_q <= bit_q;
                end
`endif
                if (cnt_q == 4'd10) begin
                    stop_q <= bit_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            sheld_q <= 1'b0;
            oheld_q <= 1'b0;
            space_q <= 1'b0;
            one_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 8'h00;
        end else begin
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            sheld_q <= sheld_d;
            oheld_q <= oheld_d;
            space_q <= space_d;
            one_q   <= one_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign spacePressed = space_q;
    assign onePressed   = one_q;
    assign oScanValid   = valid_q;
    assign oFrameError  = err_q;
    assign oScanCode    = code_q;

endmodule
